iram_port_arbiter: RTL and testbench
====================================

Name: iram_port_arbiter

Overview:
- Shares one single-port, 1-cycle-latency instruction RAM between the CPU instruction bus (cpui_*) and the CPU data bus (cpud_*).
- Latches one-cycle requests from each bus, grants the RAM port one requester per cycle, and routes the RAM response back with ack and rdata.
- Sits between the CPU bus interface and the RAM macro, so the RAM needs only a single port.

Parameters:
- ADDR_W, 16: byte address width on all buses.
- MAX_D_STREAK, 4: maximum consecutive data grants while an instruction request waits; range 1..15.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- cpui_request  in  1  instruction read request; one-cycle pulse.
- cpui_addr  in  ADDR_W  instruction byte address.
- cpui_rdata  out  32  instruction word; 0 when cpui_ack=0.
- cpui_ack  out  1  instruction response; one-cycle pulse.
- cpud_request  in  1  data request; one-cycle pulse.
- cpud_addr  in  ADDR_W  data byte address.
- cpud_write  in  1  1=write, 0=read.
- cpud_byte_enable  in  4  write byte lanes.
- cpud_wdata  in  32  write data.
- cpud_rdata  out  32  read data; 0 unless acking a read.
- cpud_ack  out  1  data response; one-cycle pulse.
- mem_request  out  1  RAM access strobe.
- mem_addr  out  ADDR_W  RAM byte address.
- mem_write  out  1  RAM write.
- mem_byte_enable  out  4  RAM byte lanes.
- mem_wdata  out  32  RAM write data.
- mem_rdata  in  32  RAM read data; valid with mem_ack.
- mem_ack  in  1  RAM response; arrives exactly 1 cycle after mem_request.
- protocol_error  out  1  sticky protocol-violation flag.

Behaviour:
- Reset (async, resetn=0):
  - Outputs: cpui_ack=0, cpud_ack=0, mem_request=0, protocol_error=0; both rdata outputs 0.
  - State: pending flags, in-flight owner and streak counter all cleared.
- Pending registers: one per bus; hold address (plus write, byte_enable and wdata for the data bus). A request in cycle N sets the pending flag at the end of cycle N.
- Grant (combinational from pending state, once per cycle):
  - Only data pending: data wins.
  - Only instruction pending: instruction wins.
  - Both pending: data wins unless the streak counter equals MAX_D_STREAK, in which case instruction wins.
- Issue: the winner drives mem_* with mem_request=1, and its pending flag clears at that edge. One issue is allowed per cycle, so back-to-back issues are legal.
- In-flight owner register records the winner (NONE/I/D) for one cycle.
- Response: when mem_ack=1, the arbiter pulses ack to the recorded owner and forwards mem_rdata.
  - Data writes are acked with cpud_rdata=0.
  - mem_ack with owner NONE is ignored and sets protocol_error.
- Latency: uncontended request at cycle N produces mem_request at N+1 and ack at N+2.
- Streak counter:
  - Increments on a data grant while instruction is pending, saturating at MAX_D_STREAK.
  - Clears on an instruction grant, or when instruction is not pending.
- Simultaneous request and issue on the same bus in the same cycle: the new request is latched; the pending flag stays set.
- Protocol violation: a request from a bus whose pending flag is set, or whose access is in flight and not yet acked, sets protocol_error until reset. The new request is dropped and the original completes normally.
- Reset mid-operation: in-flight owner is cleared; a stale mem_ack in the first cycle after reset release is ignored and does not set protocol_error.
- No state machine beyond the owner register (NONE/I/D); owner returns to NONE on any cycle without an issue.

Optional Feature:
- IRAM_ARB_BYPASS_EN
- Defined:
  - When the requester's pending flag is clear and nothing else competes this cycle, the live cpui/cpud request is forwarded directly to mem_* in the same cycle. Uncontended latency becomes 1 cycle: request at N, ack at N+1.
  - When both requests are live and nothing is pending, data bypasses and instruction is latched to pending.
  - A pending request always beats a live one.
- Undefined: all requests go through the pending registers; latency 2.

Test Plan:
- Single instruction read, cpui_addr=0x0010, RAM returns 0xDEADBEEF -> mem_request at N+1 with mem_addr=0x0010; cpui_ack at N+2 with cpui_rdata=0xDEADBEEF; cpud_ack stays 0.
- Simultaneous cpui_request (0x0020) and cpud write (0x0100, 0x12345678, be=0xF) at cycle N -> data issued at N+1, instruction at N+2; cpud_ack at N+2 with rdata=0; cpui_ack at N+3.
- Data requests every 2 cycles while one instruction request waits, MAX_D_STREAK=4 -> instruction granted after exactly 4 data grants; streak counter cleared.
- Second cpud_request while the first data read is still pending -> protocol_error=1 and stays 1; exactly one cpud_ack occurs.
- resetn low in the cycle a data read is in flight, released next cycle, stale mem_ack arrives -> no cpud_ack, protocol_error=0, all outputs at reset values.
- With IRAM_ARB_BYPASS_EN, idle bus, cpui_request at N -> mem_request at N, cpui_ack at N+1.

Source files
------------

// File: rtl/iram_port_arbiter.sv
// iram_port_arbiter
// Shares one single-port, 1-cycle-latency instruction RAM between the CPU
// instruction bus (cpui_*) and the CPU data bus (cpud_*). Each bus has a
// one-deep pending register; one requester is issued to the RAM per cycle
// and the RAM response is routed back to whoever owned that issue.
//
// Build option: define IRAM_ARB_BYPASS_EN to forward an uncontended live
// request straight to the RAM in the same cycle (latency 1 instead of 2).
module iram_port_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int MAX_D_STREAK = 4     // 1..15
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              cpui_request,
    input  logic [ADDR_W-1:0] cpui_addr,
    output logic [31:0]       cpui_rdata,
    output logic              cpui_ack,
    input  logic              cpud_request,
    input  logic [ADDR_W-1:0] cpud_addr,
    input  logic              cpud_write,
    input  logic [3:0]        cpud_byte_enable,
    input  logic [31:0]       cpud_wdata,
    output logic [31:0]       cpud_rdata,
    output logic              cpud_ack,
    output logic              mem_request,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_write,
    output logic [3:0]        mem_byte_enable,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic              protocol_error
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } owner_t;

    localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);

    // Pending request state (flags are reset, payload is not)
    logic              r_i_pend;
    logic [ADDR_W-1:0] r_i_addr;
    logic              r_d_pend;
    logic [ADDR_W-1:0] r_d_addr;
    logic              r_d_write;
    logic [3:0]        r_d_be;
    logic [31:0]       r_d_wdata;

    // Access bookkeeping
    owner_t            r_owner;          // who owns the access whose ack is due now
    logic              r_d_wr_inflight;  // in-flight data access is a write
    logic [3:0]        r_streak;         // data grants while instruction waits
    logic              r_rst_guard;      // high for the first cycle after reset

    logic w_streak_full;
    logic w_grant_i;
    logic w_grant_d;
    logic w_byp_i;
    logic w_byp_d;
    logic w_issue_i;
    logic w_issue_d;
    logic w_i_viol;
    logic w_d_viol;
    logic w_i_load;
    logic w_d_load;
    logic w_stray_ack;

    // Arbitration among pending requests: data first, unless instruction has
    // already watched MAX_D_STREAK data grants go by.
    assign w_streak_full = (r_streak == STREAK_MAX);
    assign w_grant_d     = r_d_pend & (~r_i_pend | ~w_streak_full);
    assign w_grant_i     = r_i_pend & (~r_d_pend |  w_streak_full);

    // A new request is illegal if its bus already has a request waiting that
    // is not leaving this cycle, or an access whose ack has not come back yet.
    assign w_i_viol = cpui_request &
                      ((r_i_pend & ~w_grant_i) | ((r_owner == OWN_I) & ~mem_ack));
    assign w_d_viol = cpud_request &
                      ((r_d_pend & ~w_grant_d) | ((r_owner == OWN_D) & ~mem_ack));

`ifdef IRAM_ARB_BYPASS_EN
    // Live requests go straight to the RAM only when nothing is pending;
    // data wins a tie and the instruction request is parked.
    assign w_byp_d = ~r_i_pend & ~r_d_pend & cpud_request & ~w_d_viol;
    assign w_byp_i = ~r_i_pend & ~r_d_pend & cpui_request & ~w_i_viol & ~w_byp_d;
`else
    assign w_byp_d = 1'b0;
    assign w_byp_i = 1'b0;
`endif

    assign w_issue_d = w_grant_d | w_byp_d;
    assign w_issue_i = w_grant_i | w_byp_i;

    // Legal requests that were not bypassed are captured into pending
    assign w_i_load = cpui_request & ~w_i_viol & ~w_byp_i;
    assign w_d_load = cpud_request & ~w_d_viol & ~w_byp_d;

    // An ack with no owner is a RAM-side violation, except the stale one that
    // can trail a reset that cut an access short.
    assign w_stray_ack = mem_ack & (r_owner == OWN_NONE) & ~r_rst_guard;

    // RAM port mux: drive the single winner of this cycle, idle-zero otherwise
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch.
        mem_request     = 1'b0;
        mem_addr        = '0;
        mem_write       = 1'b0;
        mem_byte_enable = 4'h0;
        mem_wdata       = 32'h0;
        if (w_grant_d) begin
            mem_request     = 1'b1;
            mem_addr        = r_d_addr;
            mem_write       = r_d_write;
            mem_byte_enable = r_d_be;
            mem_wdata       = r_d_wdata;
        end else if (w_byp_d) begin
            mem_request     = 1'b1;
            mem_addr        = cpud_addr;
            mem_write       = cpud_write;
            mem_byte_enable = cpud_byte_enable;
            mem_wdata       = cpud_wdata;
        end else if (w_grant_i) begin
            mem_request     = 1'b1;
            mem_addr        = r_i_addr;
        end else if (w_byp_i) begin
            mem_request     = 1'b1;
            mem_addr        = cpui_addr;
        end
    end

    // Response routing: ack the recorded owner, zero rdata when not acking a read
    always_comb begin
        cpui_ack   = mem_ack & (r_owner == OWN_I);
        cpud_ack   = mem_ack & (r_owner == OWN_D);
        cpui_rdata = cpui_ack ? mem_rdata : 32'h0;
        cpud_rdata = (cpud_ack & ~r_d_wr_inflight) ? mem_rdata : 32'h0;
    end

    // Control state: pending flags, owner, streak counter and error flag
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_i_pend        <= 1'b0;
            r_d_pend        <= 1'b0;
            r_owner         <= OWN_NONE;
            r_d_wr_inflight <= 1'b0;
            r_streak        <= 4'h0;
            r_rst_guard     <= 1'b1;
            protocol_error  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register sees the
            // pre-edge values computed by the combinational logic above.
            r_rst_guard <= 1'b0;

            // A fresh request wins over the issue clear on the same bus
            if (w_i_load)       r_i_pend <= 1'b1;
            else if (w_grant_i) r_i_pend <= 1'b0;

            if (w_d_load)       r_d_pend <= 1'b1;
            else if (w_grant_d) r_d_pend <= 1'b0;

            if (w_issue_d)      r_owner <= OWN_D;
            else if (w_issue_i) r_owner <= OWN_I;
            else                r_owner <= OWN_NONE;

            r_d_wr_inflight <= w_issue_d & mem_write;

            if (w_issue_i || !r_i_pend)
                r_streak <= 4'h0;
            else if (w_issue_d && !w_streak_full)
                r_streak <= r_streak + 4'd1;

            if (w_i_viol || w_d_viol || w_stray_ack)
                protocol_error <= 1'b1;
        end
    end

    // Request payload capture, qualified by the pending flags above
    always_ff @(posedge clock) begin
        // NOTE: payload registers are deliberately left out of reset; they
        // are only observed when their pending flag is set.
        if (w_i_load) begin
            r_i_addr <= cpui_addr;
        end
        if (w_d_load) begin
            r_d_addr  <= cpud_addr;
            r_d_write <= cpud_write;
            r_d_be    <= cpud_byte_enable;
            r_d_wdata <= cpud_wdata;
        end
    end

endmodule

// File: tb/tb_iram_port_arbiter.sv
// Self-checking bench for iram_port_arbiter. A small RAM model answers every
// mem_request one cycle later; expected RAM issues and bus acks are queued
// when stimulus is driven and compared when the DUT produces them.
// Honours IRAM_ARB_BYPASS_EN for the expected latencies and schedules.
module tb_iram_port_arbiter;

`ifdef IRAM_ARB_BYPASS_EN
    localparam int L = 0;
`else
    localparam int L = 1;
`endif

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        cpui_request = 1'b0;
    logic [15:0] cpui_addr = '0;
    logic [31:0] cpui_rdata;
    logic        cpui_ack;
    logic        cpud_request = 1'b0;
    logic [15:0] cpud_addr = '0;
    logic        cpud_write = 1'b0;
    logic [3:0]  cpud_byte_enable = '0;
    logic [31:0] cpud_wdata = '0;
    logic [31:0] cpud_rdata;
    logic        cpud_ack;
    logic        mem_request;
    logic [15:0] mem_addr;
    logic        mem_write;
    logic [3:0]  mem_byte_enable;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic        protocol_error;

    iram_port_arbiter #(.ADDR_W(16), .MAX_D_STREAK(4)) dut (
        .clock            (clock),
        .resetn           (resetn),
        .cpui_request     (cpui_request),
        .cpui_addr        (cpui_addr),
        .cpui_rdata       (cpui_rdata),
        .cpui_ack         (cpui_ack),
        .cpud_request     (cpud_request),
        .cpud_addr        (cpud_addr),
        .cpud_write       (cpud_write),
        .cpud_byte_enable (cpud_byte_enable),
        .cpud_wdata       (cpud_wdata),
        .cpud_rdata       (cpud_rdata),
        .cpud_ack         (cpud_ack),
        .mem_request      (mem_request),
        .mem_addr         (mem_addr),
        .mem_write        (mem_write),
        .mem_byte_enable  (mem_byte_enable),
        .mem_wdata        (mem_wdata),
        .mem_rdata        (mem_rdata),
        .mem_ack          (mem_ack),
        .protocol_error   (protocol_error)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [15:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          cyc;
    } mem_exp_t;

    typedef struct {
        bit          is_d;
        logic [31:0] rdata;
        int          cyc;
    } ack_exp_t;

    mem_exp_t    exp_mem[$];
    ack_exp_t    exp_ack[$];
    logic [31:0] ram [logic [15:0]];

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    bit   g_rst_pulse = 1'b0;
    bit   g_spurious  = 1'b0;
    logic ram_ack_next = 1'b0;
    logic [31:0] ram_rdata_next = '0;

    function automatic logic [31:0] ram_read(input logic [15:0] a);
        if (ram.exists(a)) return ram[a];
        return {16'hC0DE, a};
    endfunction

    // Queue one expected RAM issue and, optionally, its bus ack a cycle later
    task automatic push_issue(input logic [15:0] a, input logic w, input logic [31:0] wd,
                              input logic [3:0] be, input int c, input bit is_d,
                              input bit with_ack);
        mem_exp_t m;
        ack_exp_t k;
        m.addr = a; m.write = w; m.wdata = wd; m.be = be; m.cyc = c;
        exp_mem.push_back(m);
        if (with_ack) begin
            k.is_d  = is_d;
            k.rdata = w ? 32'h0 : ram_read(a);
            k.cyc   = c + 1;
            exp_ack.push_back(k);
        end
    endtask

    // One clock cycle: score outputs at negedge, run the RAM model, then
    // drop request pulses and present the RAM response after the edge.
    task automatic tick();
        mem_exp_t m;
        ack_exp_t k;
        logic [31:0] got_rd;
        @(negedge clock);
        if (mem_request) begin
            n_cmp++;
            if (exp_mem.size() == 0) begin
                n_bad++;
                $display("FAIL mem_issue: unexpected request addr=%h wr=%b at cycle %0d, expected none",
                         mem_addr, mem_write, cyc);
            end else begin
                m = exp_mem.pop_front();
                if (mem_addr !== m.addr || mem_write !== m.write || cyc != m.cyc ||
                    (m.write && (mem_wdata !== m.wdata || mem_byte_enable !== m.be))) begin
                    n_bad++;
                    $display("FAIL mem_issue: got addr=%h wr=%b wd=%h be=%h cyc=%0d, expected addr=%h wr=%b wd=%h be=%h cyc=%0d",
                             mem_addr, mem_write, mem_wdata, mem_byte_enable, cyc,
                             m.addr, m.write, m.wdata, m.be, m.cyc);
                end
            end
            ram_ack_next = 1'b1;
            if (mem_write) begin
                logic [31:0] cur;
                cur = ram_read(mem_addr);
                for (int b = 0; b < 4; b++)
                    if (mem_byte_enable[b]) cur[b*8 +: 8] = mem_wdata[b*8 +: 8];
                ram[mem_addr] = cur;
                ram_rdata_next = 32'hBAD0_BAD0;   // junk that must not reach cpud_rdata
            end else begin
                ram_rdata_next = ram_read(mem_addr);
            end
        end else begin
            ram_ack_next   = g_spurious;
            ram_rdata_next = 32'h5A5A_5A5A;
        end

        if (cpui_ack || cpud_ack) begin
            n_cmp++;
            got_rd = cpud_ack ? cpud_rdata : cpui_rdata;
            if (exp_ack.size() == 0) begin
                n_bad++;
                $display("FAIL bus_ack: unexpected ack i=%b d=%b rdata=%h at cycle %0d, expected none",
                         cpui_ack, cpud_ack, got_rd, cyc);
            end else begin
                k = exp_ack.pop_front();
                if ((cpui_ack && cpud_ack) || cpud_ack !== k.is_d || got_rd !== k.rdata || cyc != k.cyc) begin
                    n_bad++;
                    $display("FAIL bus_ack: got i=%b d=%b rdata=%h cyc=%0d, expected d=%b rdata=%h cyc=%0d",
                             cpui_ack, cpud_ack, got_rd, cyc, k.is_d, k.rdata, k.cyc);
                end
            end
        end
        n_cmp++;
        if ((!cpui_ack && cpui_rdata !== 32'h0) || (!cpud_ack && cpud_rdata !== 32'h0)) begin
            n_bad++;
            $display("FAIL idle_rdata: got i=%h d=%h at cycle %0d, expected 0 without ack",
                     cpui_rdata, cpud_rdata, cyc);
        end

        if (g_rst_pulse) resetn = 1'b0;
        @(posedge clock);
        cyc++;
        #1;
        if (g_rst_pulse) begin
            resetn      = 1'b1;
            g_rst_pulse = 1'b0;
        end
        mem_ack      = ram_ack_next;
        mem_rdata    = ram_rdata_next;
        g_spurious   = 1'b0;
        cpui_request = 1'b0;
        cpud_request = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (2) begin
            @(negedge clock);
            n_cmp++;
            if ({cpui_ack, cpud_ack, mem_request, protocol_error, cpui_rdata, cpud_rdata} !== '0) begin
                n_bad++;
                $display("FAIL reset_outputs: got iack=%b dack=%b mreq=%b perr=%b, expected all 0",
                         cpui_ack, cpud_ack, mem_request, protocol_error);
            end
        end
        @(posedge clock);
        #1;
        resetn = 1'b1;
        cyc = 0;
        repeat (2) tick();
    endtask

    task automatic test_single_read();
        int n;
        n = cyc;
        cpui_request = 1'b1;
        cpui_addr    = 16'h0010;
        push_issue(16'h0010, 1'b0, 32'h0, 4'h0, n + L, 1'b0, 1'b1);
        repeat (4) tick();
        n_cmp++;
        if (exp_mem.size() != 0 || exp_ack.size() != 0) begin
            n_bad++;
            $display("FAIL single_read_drain: got %0d issues / %0d acks outstanding, expected 0 / 0",
                     exp_mem.size(), exp_ack.size());
        end
    endtask

    task automatic test_contention();
        int n;
        n = cyc;
        cpui_request     = 1'b1;
        cpui_addr        = 16'h0020;
        cpud_request     = 1'b1;
        cpud_addr        = 16'h0100;
        cpud_write       = 1'b1;
        cpud_byte_enable = 4'hF;
        cpud_wdata       = 32'h1234_5678;
        push_issue(16'h0100, 1'b1, 32'h1234_5678, 4'hF, n + L,     1'b1, 1'b1);
        push_issue(16'h0020, 1'b0, 32'h0,         4'h0, n + L + 1, 1'b0, 1'b1);
        repeat (5) tick();
        cpud_write = 1'b0;
        n_cmp++;
        if (exp_mem.size() != 0 || exp_ack.size() != 0) begin
            n_bad++;
            $display("FAIL contention_drain: got %0d issues / %0d acks outstanding, expected 0 / 0",
                     exp_mem.size(), exp_ack.size());
        end
        n_cmp++;
        if (ram_read(16'h0100) !== 32'h1234_5678) begin
            n_bad++;
            $display("FAIL contention_write: ram[0100] got %h, expected 12345678", ram_read(16'h0100));
        end
    endtask

    // Back-to-back data reads while an instruction request waits. With viol
    // set, an extra data request lands while the previous one is parked.
    task automatic run_streak(input bit viol);
        logic [8:0]  d_mask;
        logic [8:0]  i_mask;
        string       iss;
        int          t_viol;
        int          n;
        byte         c;
        logic [15:0] next_d;
        logic [15:0] next_i;
        logic [15:0] dq[$];
        logic [15:0] iq[$];
        bit          exp_pe;
`ifdef IRAM_ARB_BYPASS_EN
        d_mask = 9'b001111111; i_mask = 9'b000000101; iss = "DIDDDDDID"; t_viol = 7;
`else
        d_mask = 9'b000111111; i_mask = 9'b000000010; iss = "-DDDDDID-"; t_viol = 6;
`endif
        n      = cyc;
        next_d = viol ? 16'h0300 : 16'h0200;
        next_i = viol ? 16'h0060 : 16'h0040;
        for (int t = 0; t < 9; t++) begin
            if (d_mask[t]) begin
                cpud_request     = 1'b1;
                cpud_addr        = next_d;
                cpud_write       = 1'b0;
                cpud_byte_enable = 4'hF;
                dq.push_back(next_d);
                next_d = next_d + 16'd4;
            end
            if (viol && t == t_viol) begin
                cpud_request = 1'b1;
                cpud_addr    = 16'h0F00;
                cpud_write   = 1'b0;
            end
            if (i_mask[t]) begin
                cpui_request = 1'b1;
                cpui_addr    = next_i;
                iq.push_back(next_i);
                next_i = next_i + 16'd4;
            end
            c = iss[t];
            if (c == "D")
                push_issue(dq.pop_front(), 1'b0, 32'h0, 4'hF, n + t, 1'b1, 1'b1);
            else if (c == "I")
                push_issue(iq.pop_front(), 1'b0, 32'h0, 4'h0, n + t, 1'b0, 1'b1);
            tick();
            exp_pe = viol && (t >= t_viol);
            n_cmp++;
            if (protocol_error !== exp_pe) begin
                n_bad++;
                $display("FAIL streak_perr: step %0d got protocol_error=%b, expected %b",
                         t, protocol_error, exp_pe);
            end
        end
        repeat (2) tick();
        n_cmp++;
        if (exp_mem.size() != 0 || exp_ack.size() != 0) begin
            n_bad++;
            $display("FAIL streak_drain: got %0d issues / %0d acks outstanding, expected 0 / 0",
                     exp_mem.size(), exp_ack.size());
        end
    endtask

    task automatic test_streak();
        run_streak(1'b0);
    endtask

    task automatic test_protocol();
        run_streak(1'b1);
    endtask

    task automatic test_reset_midflight();
        int n;
        n_cmp++;
        if (protocol_error !== 1'b1) begin
            n_bad++;
            $display("FAIL perr_sticky: got %b, expected 1", protocol_error);
        end
        n = cyc;
        cpud_request = 1'b1;
        cpud_addr    = 16'h0500;
        cpud_write   = 1'b0;
        push_issue(16'h0500, 1'b0, 32'h0, 4'hF, n + L, 1'b1, 1'b0);
        if (L == 0) g_rst_pulse = 1'b1;
        tick();
        if (L == 1) begin
            g_rst_pulse = 1'b1;
            tick();
        end
        // Stale mem_ack is on the bus in this cycle
        n_cmp++;
        if (mem_ack !== 1'b1) begin
            n_bad++;
            $display("FAIL stale_ack_setup: got mem_ack=%b, expected 1", mem_ack);
        end
        tick();
        n_cmp++;
        if ({cpui_ack, cpud_ack, mem_request, protocol_error, cpui_rdata, cpud_rdata} !== '0) begin
            n_bad++;
            $display("FAIL reset_midflight: got iack=%b dack=%b mreq=%b perr=%b, expected all 0",
                     cpui_ack, cpud_ack, mem_request, protocol_error);
        end
        n_cmp++;
        if (exp_mem.size() != 0 || exp_ack.size() != 0) begin
            n_bad++;
            $display("FAIL midflight_drain: got %0d issues / %0d acks outstanding, expected 0 / 0",
                     exp_mem.size(), exp_ack.size());
        end
    endtask

    task automatic test_spurious_ack();
        tick();
        g_spurious = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (protocol_error !== 1'b1) begin
            n_bad++;
            $display("FAIL spurious_ack: got protocol_error=%b, expected 1", protocol_error);
        end
    endtask

    initial begin
        ram[16'h0010] = 32'hDEAD_BEEF;
        test_reset();
        test_single_read();
        test_contention();
        test_streak();
        test_protocol();
        test_reset_midflight();
        test_spurious_ack();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion by 100000, expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
